// File: rtl/crc32_serial_checker.sv
// Serial CRC-32 receive checker: data MSB-first then 32 CRC bits; strips CRC, flags pass/fail.
// Data forwarded with 1-cycle latency; bit_valid low stalls all state, start restarts at any time.
module crc32_serial_checker #(
   parameter logic [31:0] POLY  = 32'h8000_0005,
   parameter logic [31:0] INIT  = 32'h0000_0000,
   parameter int          LEN_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_bit_in,
   input  logic             i_bit_valid,
   input  logic             i_data_last,
   output logic             o_data_out,
   output logic             o_data_out_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_crc_ok,
   output logic             o_crc_err,
   output logic             o_len_err,
   output logic [LEN_W-1:0] o_frame_len,
   output logic [31:0]      o_rx_crc,
   output logic [31:0]      o_calc_crc
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

   state_t           r_state;
   logic [31:0]      r_lfsr;
   logic [4:0]       r_crc_cnt;
   logic             r_data_out;
   logic             r_data_out_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_crc_ok;
   logic             r_crc_err;
   logic             r_len_err;
   logic [LEN_W-1:0] r_frame_len;
   logic [31:0]      r_rx_crc;
   logic [31:0]      r_calc_crc;

   logic        w_fb;
   logic [31:0] w_lfsr_nxt;
   logic        w_rem_zero;

   assign w_fb       = r_lfsr[31] ^ i_bit_in;
   assign w_lfsr_nxt = {r_lfsr[30:0], 1'b0} ^ (w_fb ? POLY : 32'h0);
   assign w_rem_zero = (w_lfsr_nxt == 32'h0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= S_IDLE;
         r_lfsr           <= INIT;
         r_crc_cnt        <= '0;
         r_data_out       <= 1'b0;
         r_data_out_valid <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_crc_ok         <= 1'b0;
         r_crc_err        <= 1'b0;
         r_len_err        <= 1'b0;
         r_frame_len      <= '0;
         r_rx_crc         <= '0;
         r_calc_crc       <= '0;
      end else begin
         r_data_out_valid <= 1'b0;
         r_done           <= 1'b0;
         // start wins in every state: opens a frame from IDLE/DONE, aborts one in DATA/CRC
         if (i_start) begin
            r_state     <= S_DATA;
            r_lfsr      <= INIT;
            r_crc_cnt   <= '0;
            r_busy      <= 1'b1;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_len <= '0;
         end else begin
            case (r_state)
               S_DATA: begin
                  if (i_bit_valid) begin
                     r_lfsr           <= w_lfsr_nxt;
                     r_data_out       <= i_bit_in;
                     r_data_out_valid <= 1'b1;
                     if (&r_frame_len)
                        r_len_err <= 1'b1;
                     else
                        r_frame_len <= r_frame_len + 1'b1;
                     if (i_data_last) begin
                        r_calc_crc <= w_lfsr_nxt;
                        r_crc_cnt  <= '0;
                        r_state    <= S_CRC;
                     end
                  end
               end
               S_CRC: begin
                  if (i_bit_valid) begin
                     r_lfsr    <= w_lfsr_nxt;
                     r_rx_crc  <= {r_rx_crc[30:0], i_bit_in};
                     r_crc_cnt <= r_crc_cnt + 1'b1;
                     // verdict is registered on the last CRC bit so it is valid alongside done
                     if (r_crc_cnt == 5'd31) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_crc_ok  <= w_rem_zero && !r_len_err;
                        r_crc_err <= !(w_rem_zero && !r_len_err);
                     end
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_data_out       = r_data_out;
   assign o_data_out_valid = r_data_out_valid;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_crc_ok         = r_crc_ok;
   assign o_crc_err        = r_crc_err;
   assign o_len_err        = r_len_err;
   assign o_frame_len      = r_frame_len;
   assign o_rx_crc         = r_rx_crc;
   assign o_calc_crc       = r_calc_crc;

endmodule

// File: tb/tb_crc32_serial_checker.sv
// Directed bench for crc32_serial_checker: a default-width instance plus a LEN_W=4 instance
// for counter saturation, both fed from the same stimulus.
module tb_crc32_serial_checker;

   logic clk = 1'b0;
   logic rst, start, bit_in, bit_valid, data_last;

   logic        d_out, d_vld, d_busy, d_done, d_ok, d_err, d_lerr;
   logic [15:0] d_flen;
   logic [31:0] d_rx, d_calc;

   logic        s_out, s_vld, s_busy, s_done, s_ok, s_err, s_lerr;
   logic [3:0]  s_flen;
   logic [31:0] s_rx, s_calc;

   int n_pass = 0;
   int n_total = 0;
   int vld_cnt = 0;
   int done_cnt = 0;
   logic last_dout = 1'b0;
   int v0, dn0;

   crc32_serial_checker dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_bit_in(bit_in),
      .i_bit_valid(bit_valid), .i_data_last(data_last),
      .o_data_out(d_out), .o_data_out_valid(d_vld), .o_busy(d_busy), .o_done(d_done),
      .o_crc_ok(d_ok), .o_crc_err(d_err), .o_len_err(d_lerr), .o_frame_len(d_flen),
      .o_rx_crc(d_rx), .o_calc_crc(d_calc)
   );

   crc32_serial_checker #(.LEN_W(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_bit_in(bit_in),
      .i_bit_valid(bit_valid), .i_data_last(data_last),
      .o_data_out(s_out), .o_data_out_valid(s_vld), .o_busy(s_busy), .o_done(s_done),
      .o_crc_ok(s_ok), .o_crc_err(s_err), .o_len_err(s_lerr), .o_frame_len(s_flen),
      .o_rx_crc(s_rx), .o_calc_crc(s_calc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (d_vld) begin
         vld_cnt++;
         last_dout = d_out;
      end
      if (d_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic b, input logic last, input int stall);
      bit_valid = 1'b0;
      repeat (stall) @(negedge clk);
      bit_in = b;
      data_last = last;
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      data_last = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int stall);
      for (int i = 31; i >= 0; i--) send(w[i], 1'b0, stall);
   endtask

   task automatic send_zero_data(input int n);
      for (int i = 0; i < n; i++) send(1'b0, i == n - 1, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; data_last = 1'b0;
      tick(2);
      chk("reset_ctl", {9'd0, d_out, d_vld, d_busy, d_done, d_ok, d_err, d_lerr, d_flen}, 32'd0);
      chk("reset_rx", d_rx, 32'd0);
      chk("reset_calc", d_calc, 32'd0);
      rst = 1'b0;
      tick(1);

      // clean zero frame
      #1; v0 = vld_cnt; dn0 = done_cnt;
      @(negedge clk);
      do_start();
      chk("zero_busy", d_busy, 1);
      send_zero_data(8);
      send_word(32'h0, 0);
      chk("zero_done", d_done, 1);
      chk("zero_ok", {d_ok, d_err}, 2'b10);
      chk("zero_len", d_flen, 8);
      chk("zero_calc", d_calc, 32'h0);
      chk("zero_rx", d_rx, 32'h0);
      chk("zero_busy_end", d_busy, 0);
      tick(1);
      chk("zero_done_pulse", d_done, 0);
      chk("zero_ok_hold", d_ok, 1);
      #1;
      chk("zero_vld_cnt", vld_cnt - v0, 8);
      chk("zero_done_cnt", done_cnt - dn0, 1);

      // single-bit frame
      v0 = vld_cnt;
      @(negedge clk);
      do_start();
      send(1'b1, 1'b1, 0);
      send_word(32'h8000_0005, 0);
      chk("one_calc", d_calc, 32'h8000_0005);
      chk("one_ok", {d_ok, d_err}, 2'b10);
      chk("one_len", d_flen, 1);
      #1;
      chk("one_vld_cnt", vld_cnt - v0, 1);
      chk("one_dout", last_dout, 1);

      // two-bit frame, good then with CRC bit 0 flipped
      @(negedge clk);
      do_start();
      send(1'b1, 1'b0, 0);
      send(1'b0, 1'b1, 0);
      send_word(32'h8000_000F, 0);
      chk("two_calc", d_calc, 32'h8000_000F);
      chk("two_ok", {d_ok, d_err}, 2'b10);
      do_start();
      send(1'b1, 1'b0, 0);
      send(1'b0, 1'b1, 0);
      send_word(32'h8000_000E, 0);
      chk("two_bad_done", d_done, 1);
      chk("two_bad_err", {d_ok, d_err}, 2'b01);
      chk("two_bad_rx", d_rx, 32'h8000_000E);

      // two-bit frame with 3 stall cycles before every bit
      tick(1);
      #1; v0 = vld_cnt;
      @(negedge clk);
      do_start();
      send(1'b1, 1'b0, 3);
      send(1'b0, 1'b1, 3);
      send_word(32'h8000_000F, 3);
      chk("stall_ok", {d_ok, d_err}, 2'b10);
      chk("stall_calc", d_calc, 32'h8000_000F);
      chk("stall_len", d_flen, 2);
      #1;
      chk("stall_vld_cnt", vld_cnt - v0, 2);

      // abort mid-CRC, then a clean frame; start coincident with its done
      dn0 = done_cnt;
      @(negedge clk);
      do_start();
      send_zero_data(8);
      for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 0);
      do_start();
      chk("abort_busy", d_busy, 1);
      send_zero_data(8);
      send_word(32'h0, 0);
      chk("abort_clean_ok", {d_ok, d_err}, 2'b10);
      chk("abort_clean_done", d_done, 1);
      do_start();
      chk("dstart_busy", d_busy, 1);
      chk("dstart_ok_clr", d_ok, 0);
      send(1'b0, 1'b1, 0);
      send_word(32'h0, 0);
      chk("dstart_ok", {d_ok, d_err}, 2'b10);
      chk("dstart_len", d_flen, 1);
      #1;
      chk("abort_done_cnt", done_cnt - dn0, 2);

      // reset mid-DATA
      @(negedge clk);
      do_start();
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_ctl", {9'd0, d_out, d_vld, d_busy, d_done, d_ok, d_err, d_lerr, d_flen}, 32'd0);
      chk("rst_rx", d_rx, 32'h0);
      chk("rst_calc", d_calc, 32'h0);
      #1; v0 = vld_cnt;
      @(negedge clk);
      send(1'b1, 1'b1, 0);
      tick(1);
      chk("rst_idle_busy", d_busy, 0);
      #1;
      chk("rst_idle_vld", vld_cnt - v0, 0);

      // length saturation on the LEN_W=4 instance
      @(negedge clk);
      do_start();
      send_zero_data(20);
      send_word(32'h0, 0);
      chk("sat_done", s_done, 1);
      chk("sat_len", s_flen, 15);
      chk("sat_lerr", s_lerr, 1);
      chk("sat_res", {s_ok, s_err}, 2'b01);
      chk("wide_len", d_flen, 20);
      chk("wide_ok", {d_ok, d_lerr}, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/crc32_serial_checker.md
Name: crc32_serial_checker

Overview:
- Receive-side companion of the serial CRC-32 generator: consumes the serial stream that generator emits, i.e. data bits MSB-first followed by 32 CRC bits MSB-first.
- Runs the same LFSR over data plus CRC, strips the CRC field from the forwarded data, and reports pass/fail, frame length and captured/computed CRC values.
- Sits between the serial link deserialiser input and the frame consumer.

Parameters:
- POLY, 32'h8000_0005, feedback tap mask (x^32+x^31+x^2+1; taps bits 31, 2, 0).
- INIT, 32'h0000_0000, LFSR value loaded on start.
- LEN_W, 16, width of data-bit counter / frame_len.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; opens a new frame
- bit_in  in  1  serial bit (data, then CRC)
- bit_valid  in  1  bit_in qualifier; low = stall, no state change
- data_last  in  1  with bit_valid, marks the final data bit
- data_out  out  1  forwarded data bit (CRC bits never forwarded)
- data_out_valid  out  1  one-cycle strobe per forwarded data bit
- busy  out  1  high in DATA or CRC
- done  out  1  one-cycle pulse at end of frame
- crc_ok  out  1  result valid from done until next start; 1 = remainder zero
- crc_err  out  1  complement of crc_ok, qualified the same way
- len_err  out  1  data counter saturated during frame
- frame_len  out  LEN_W  number of data bits in the last frame
- rx_crc  out  32  received CRC field, MSB-first assembled
- calc_crc  out  32  LFSR value after the last data bit

Behaviour:
- LFSR step on each accepted bit:
  - fb = r[31]^bit_in.
  - r <= {r[30:0],1'b0} ^ (fb ? POLY : 0).
  - Identical to the generator, so a clean frame leaves r == 0 after the CRC field.
- Reset, synchronous with rst high:
  - state=IDLE, r=INIT, counters 0.
  - All outputs 0, including rx_crc, calc_crc and frame_len.
- State machine:
  - IDLE:
    - start -> DATA; r=INIT; frame_len=0; crc_ok/crc_err/len_err cleared.
    - Bits are ignored in IDLE.
  - DATA, per accepted bit:
    - LFSR step.
    - data_out=bit_in and data_out_valid=1 on the next cycle (1-cycle latency).
    - frame_len increments; saturates at all-ones and sets len_err sticky.
    - If data_last: calc_crc <= next r, crc_cnt=0 -> CRC.
  - CRC, per accepted bit:
    - LFSR step; rx_crc <= {rx_crc[30:0],bit_in}; crc_cnt++.
    - On the 32nd bit (crc_cnt==31 accepted) -> DONE.
  - DONE (one cycle):
    - done=1; crc_ok = (r==0) && !len_err; crc_err = !crc_ok; -> IDLE.
    - Results hold until the next start.
- Start outside IDLE:
  - During DATA/CRC: aborts the frame and restarts DATA with r=INIT; no done pulse.
  - Coincident with DONE: DONE completes, the start is honoured and the next state is DATA; done and the new frame's first accepted cycle may not overlap.
  - Simplest legal form: the start is captured, and the first bit is accepted one cycle later.
- data_last outside DATA is ignored; data_last on a stalled cycle (bit_valid=0) is ignored.
- Minimum frame is 1 data bit. A zero-length frame is not supported; the data_last-first bit counts as data.
- rst mid-frame: immediate return to IDLE with all outputs 0; no done.
- bit_valid may drop for any number of cycles in DATA or CRC; the frame resumes exactly.

Test Plan:
- Clean zero frame:
  - Stimulus: start; 8 data bits 0 (last on 8th), then 32 CRC bits 0.
  - Response: calc_crc=0, rx_crc=0, frame_len=8, done pulse, crc_ok=1.
- Single-bit frame:
  - Stimulus: start; data '1' with data_last, then CRC 0x80000005 MSB-first.
  - Response: calc_crc=0x80000005, crc_ok=1, frame_len=1, exactly one data_out_valid strobe with data_out=1.
- Two-bit frame:
  - Stimulus: data "1","0", then CRC 0x8000000F.
  - Response: crc_ok=1.
  - Repeat with CRC bit 0 flipped (0x8000000E): crc_err=1, rx_crc=0x8000000E.
- Stall robustness:
  - Stimulus: the two-bit frame with bit_valid low for 3 cycles between every bit.
  - Response: identical results; data_out_valid count = 2.
- Abort and reset:
  - Stimulus: start mid-CRC phase, then a clean zero frame.
  - Response: no done for the aborted frame; the clean frame reports crc_ok=1.
  - Stimulus: rst asserted mid-DATA.
  - Response: all outputs 0 next cycle; state IDLE.
- Length saturation:
  - Stimulus: LEN_W=4, 20 zero data bits + 32 zero CRC bits.
  - Response: frame_len=15, len_err=1, crc_ok=0, crc_err=1.
